// File: rtl/universal_shift_reg_if.sv
// Bus bundle for the universal shift register: control, serial and
// parallel data in, register contents and frame status out.
interface universal_shift_reg_if #(
    parameter int WIDTH = 8
);
    logic [2:0]       mode;
    logic             start;
    logic             sin_r;
    logic             sin_l;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             sout_msb;
    logic             sout_lsb;
    logic             busy;
    logic             done;

    modport master (
        output mode, start, sin_r, sin_l, d,
        input  q, sout_msb, sout_lsb, busy, done
    );

    modport slave (
        input  mode, start, sin_r, sin_l, d,
        output q, sout_msb, sout_lsb, busy, done
    );
endinterface

// File: rtl/universal_shift_reg.sv
// Parametrised universal shift register with manual shift/rotate/load/clear
// and an autonomous WIDTH-cycle frame engine with busy/done status.
module universal_shift_reg #(
    parameter int               WIDTH     = 8,
    parameter int               LSB_FIRST = 0,
    parameter logic [WIDTH-1:0] RST_VAL   = '0
) (
    input logic                  clk,
    input logic                  rst,
    universal_shift_reg_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] frame_shift;

    // Frame direction is fixed at elaboration time.
    always_comb begin
        if (LSB_FIRST != 0) begin
            frame_shift = {bus.sin_l, data_q[WIDTH-1:1]};
        end else begin
            frame_shift = {data_q[WIDTH-2:0], bus.sin_r};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    data_d  = bus.d;
                    cnt_d   = CNT_INIT;
                    state_d = SHIFT;
                end else begin
                    case (bus.mode)
                        3'd1:    data_d = {data_q[WIDTH-2:0], bus.sin_r};
                        3'd2:    data_d = {bus.sin_l, data_q[WIDTH-1:1]};
                        3'd3:    data_d = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
                        3'd4:    data_d = {data_q[0], data_q[WIDTH-1:1]};
                        3'd5:    data_d = bus.d;
                        3'd6:    data_d = '0;
                        default: data_d = data_q;
                    endcase
                end
            end
            SHIFT: begin
                data_d = frame_shift;
                cnt_d  = cnt_q - CNT_LAST;
                if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= RST_VAL;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    assign bus.q        = data_q;
    assign bus.sout_msb = data_q[WIDTH-1];
    assign bus.sout_lsb = data_q[0];
    assign bus.busy     = (state_q == SHIFT);
    assign bus.done     = done_q;
endmodule
